// File: rtl/seg_message_scroller.sv
// seg_message_scroller
//   Holds a message of 5-bit alphabet codes and scans it onto a multiplexed
//   bank of 7-segment digits, scrolling the visible window one character per
//   step and wrapping at the end of the message.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   wr_en/addr/data   write one alphabet code into the message buffer
//   len_wr/len_in     load message length (clamped to MAX_LEN)
//   start/stop        begin scrolling / return to idle (stop wins)
//   code_out          code for the currently enabled digit (31 = blank)
//   digit_en          one-hot active-high digit enable
//   busy              high when not idle
//   wrap              one-cycle pulse when the scroll position wraps to 0
//
// Build option
//   SCROLL_PAUSE_EN   when defined, hold position 0 for PAUSE_STEPS scroll
//                     steps after every wrap.
module seg_message_scroller #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned MAX_LEN     = 16,
    parameter int unsigned SCAN_DIV    = 1000,
    parameter int unsigned SCROLL_DIV  = 50000,
    parameter int unsigned PAUSE_STEPS = 4
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        wr_en,
    input  logic [((MAX_LEN > 1) ? $clog2(MAX_LEN) : 1)-1:0] wr_addr,
    input  logic [4:0]                                  wr_data,
    input  logic                                        len_wr,
    input  logic [$clog2(MAX_LEN+1)-1:0]                len_in,
    input  logic                                        start,
    input  logic                                        stop,
    output logic [4:0]                                  code_out,
    output logic [NUM_DIGITS-1:0]                       digit_en,
    output logic                                        busy,
    output logic                                        wrap
);

    localparam int unsigned AW  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned LW  = $clog2(MAX_LEN + 1);
    localparam int unsigned IW  = LW + 1;
    localparam int unsigned DW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned STW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

`ifdef SCROLL_PAUSE_EN
    localparam int unsigned PW = (PAUSE_STEPS > 1) ? $clog2(PAUSE_STEPS) : 1;
    typedef enum logic [1:0] {S_IDLE, S_SCROLL, S_PAUSE} state_t;
    logic [PW-1:0] pause_q, pause_d;
`else
    typedef enum logic [0:0] {S_IDLE, S_SCROLL} state_t;
`endif

    state_t              state_q, state_d;
    logic [4:0]          msg_q [MAX_LEN];
    logic [LW-1:0]       len_q, len_d, len_new;
    logic [LW-1:0]       pos_q, pos_d;
    logic [STW-1:0]      step_q, step_d;
    logic [SCW-1:0]      scan_cnt_q, scan_cnt_d;
    logic [DW-1:0]       scan_idx_q, scan_idx_d;
    logic [4:0]          code_q, code_d;
    logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
    logic                wrap_q, wrap_d;
    logic                step_tc, scan_tc;
    logic [IW-1:0]       char_idx;

    // Scan timing: digit index advances on the scan counter's terminal count.
    always_comb begin
        scan_tc    = (scan_cnt_q == SCW'(SCAN_DIV - 1));
        scan_cnt_d = scan_tc ? '0 : scan_cnt_q + 1'b1;
        scan_idx_d = scan_idx_q;
        if (scan_tc) begin
            scan_idx_d = (scan_idx_q == DW'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + 1'b1;
        end
        digit_en_d = NUM_DIGITS'(1) << scan_idx_d;
    end

    // Character for the digit that becomes active next, so that code and
    // enable register together and never disagree.
    always_comb begin
        code_d   = 5'h1F;
        char_idx = IW'(pos_q) + IW'(scan_idx_d);
        if (state_q != S_IDLE && IW'(scan_idx_d) < IW'(len_q)) begin
            if (char_idx >= IW'(len_q)) begin
                char_idx = char_idx - IW'(len_q);
            end
            if (char_idx < IW'(MAX_LEN)) begin
                code_d = msg_q[char_idx[AW-1:0]];
            end
        end
    end

    // Scroll FSM: next state, position, step counter and wrap pulse.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        len_d   = len_q;
        step_d  = step_q;
        wrap_d  = 1'b0;
`ifdef SCROLL_PAUSE_EN
        pause_d = pause_q;
`endif
        len_new = (32'(len_in) > MAX_LEN) ? LW'(MAX_LEN) : len_in;
        step_tc = (step_q == STW'(SCROLL_DIV - 1));

        case (state_q)
            S_IDLE: begin
                pos_d  = '0;
                step_d = '0;
                if (start && len_q != '0) begin
                    state_d = S_SCROLL;
                end
            end
            S_SCROLL: begin
                if (step_tc) begin
                    step_d = '0;
                    if (pos_q + 1'b1 >= len_q) begin
                        pos_d  = '0;
                        wrap_d = 1'b1;
`ifdef SCROLL_PAUSE_EN
                        state_d = S_PAUSE;
                        pause_d = '0;
`endif
                    end else begin
                        pos_d = pos_q + 1'b1;
                    end
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
`ifdef SCROLL_PAUSE_EN
            S_PAUSE: begin
                if (step_tc) begin
                    step_d = '0;
                    if (pause_q == PW'(PAUSE_STEPS - 1)) begin
                        // Last pause step doubles as the first advance off 0.
                        state_d = S_SCROLL;
                        pos_d   = (len_q > LW'(1)) ? LW'(1) : '0;
                    end else begin
                        pause_d = pause_q + 1'b1;
                    end
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (len_wr) begin
            len_d = len_new;
            // Checked against the already-advanced position so a shrink that
            // coincides with a step can never leave pos outside the message.
            if (pos_d >= len_new) begin
                pos_d = '0;
            end
            if (len_new == '0) begin
                state_d = S_IDLE;
                pos_d   = '0;
                step_d  = '0;
            end
        end

        if (stop) begin
            state_d = S_IDLE;
            pos_d   = '0;
            step_d  = '0;
            wrap_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            pos_q      <= '0;
            step_q     <= '0;
            scan_cnt_q <= '0;
            scan_idx_q <= '0;
            code_q     <= 5'h1F;
            digit_en_q <= NUM_DIGITS'(1);
            wrap_q     <= 1'b0;
`ifdef SCROLL_PAUSE_EN
            pause_q    <= '0;
`endif
            for (int unsigned k = 0; k < MAX_LEN; k++) begin
                msg_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            pos_q      <= pos_d;
            step_q     <= step_d;
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
            code_q     <= code_d;
            digit_en_q <= digit_en_d;
            wrap_q     <= wrap_d;
`ifdef SCROLL_PAUSE_EN
            pause_q    <= pause_d;
`endif
            if (wr_en && 32'(wr_addr) < MAX_LEN) begin
                msg_q[wr_addr] <= wr_data;
            end
        end
    end

    assign code_out = code_q;
    assign digit_en = digit_en_q;
    assign busy     = (state_q != S_IDLE);
    assign wrap     = wrap_q;

endmodule
